decode_skid_stage: RTL and testbench
====================================

DECODE_SKID_STAGE -- requirements
Module: decode_skid_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the width of the PC field carried with each instruction.
REQ-002 The block SHALL have parameter EN_M, default 1; when 1, RV32M ops decode as legal, and when 0 they decode as illegal.
REQ-003 The block SHALL use one clock and a synchronous active-high reset, the reset being sampled only on the rising clock edge.
REQ-004 Port clk, input, 1: the rising-edge clock.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port flush, input, 1: synchronous pipeline kill.
REQ-007 Port in_valid, input, 1: an upstream instruction is present.
REQ-008 Port in_ready, output, 1: the stage can accept an instruction; this output is driven from a register.
REQ-009 Port in_instr, input, 32: the raw instruction word.
REQ-010 Port in_pc, input, XLEN: the PC of in_instr.
REQ-011 Port out_valid, output, 1: the decoded entry is present.
REQ-012 Port out_ready, input, 1: downstream accepts the entry.
REQ-013 Port out_instr, output, 32: in_instr, passed through.
REQ-014 Port out_pc, output, XLEN: in_pc, passed through.
REQ-015 Port out_ctrl, output, 16: the decoded control fields, packed as follows:
- [15] illegal
- [14] regWrite
- [13] memWrite
- [12] memRead
- [11] branch
- [10] jump
- [9] aluSrc
- [8] inv
- [7:5] immCntrl
- [4:0] aluCntrl

Function
REQ-016 Decode SHALL be done on in_instr before storage; op=instr[6:2], f3=instr[14:12], f7=instr[31:25].
REQ-017 immCntrl encodings SHALL be: 000 none, 001 shamt, 010 I, 011 S, 100 B, 101 U, 110 J.
REQ-018 aluSrc SHALL equal the OR of the immCntrl bits; control fields not named in a decode rule SHALL be 0.
REQ-019 R-type decode (op 01100) SHALL set regWrite and immCntrl=000:
- f7 = 0000000: aluCntrl = {0,0,f3}.
- f7 = 0100000 with f3 in {000,101}: aluCntrl = {0,1,f3}.
- f7 = 0000001 with EN_M=1: aluCntrl = {1,0,f3}.
- Any other f7/f3 combination: illegal.
REQ-020 I-arith decode (op 00100) SHALL set regWrite:
- f3 in {001,101}: immCntrl=shamt.
- Other f3: immCntrl=I.
- aluCntrl = {0, f7[5]&(f3==101), f3}.
- Illegal when f3=001 and f7≠0, or when f3=101 and f7 is not in {0000000,0100000}.
REQ-021 Load decode (op 00000) SHALL set regWrite, memRead, immCntrl=I and aluCntrl=0; f3 in {011,110,111} is illegal.
REQ-022 Store decode (op 01000) SHALL set memWrite and immCntrl=S; f3>010 is illegal.
REQ-023 Branch decode (op 11000) SHALL set branch, immCntrl=B, aluCntrl={010,f3[2:1]} and inv=f3[0]; f3 in {010,011} is illegal.
REQ-024 LUI (01101) and AUIPC (00101) SHALL set regWrite and immCntrl=U.
REQ-025 JAL (11011) SHALL set regWrite, jump and immCntrl=J.
REQ-026 JALR (11001) SHALL set regWrite, jump and immCntrl=I; f3≠000 is illegal.
REQ-027 Any other op, or instr[1:0]≠11, SHALL be illegal.
REQ-028 An illegal entry SHALL carry out_ctrl = 0x8000, and SHALL still be delivered as a valid entry.
REQ-029 Storage SHALL be a 2-entry skid buffer made of an output register (OUT) and a skid register (SKID).
REQ-030 An input handshake SHALL occur when in_valid and in_ready are both 1; an output handshake when out_valid and out_ready are both 1.
REQ-031 A handshake SHALL load its entry into OUT if OUT is empty or is being consumed in the same cycle; otherwise it SHALL load into SKID.
REQ-032 When OUT is consumed while SKID is full, SKID SHALL move to OUT in that cycle.
REQ-033 in_ready SHALL be 0 exactly when SKID is full.
REQ-034 Latency SHALL be one cycle from an input handshake with the buffer empty to out_valid=1.
REQ-035 Throughput SHALL be 1 entry/cycle under continuous out_ready=1.
REQ-036 Entries SHALL leave in acceptance order.
REQ-037 out_instr, out_pc and out_ctrl SHALL remain stable while out_valid=1 and out_ready=0.
REQ-038 flush=1 SHALL empty both OUT and SKID at the next edge.
REQ-039 An input handshake in the same cycle as flush SHALL be discarded.
REQ-040 After a flush, out_valid SHALL be 0 and in_ready SHALL be 1 on the next cycle.
REQ-041 rst SHALL take priority over flush and over both handshakes.

Reset
REQ-042 On rst, out_valid SHALL be 0, SKID SHALL be empty and in_ready SHALL be 1.
REQ-043 On rst, out_ctrl, out_instr and out_pc SHALL be 0.
REQ-044 The first input handshake SHALL be possible on the first cycle after rst deasserts.

Verification
REQ-045 0x002081B3 (ADD) and 0x402081B3 (SUB) -> regWrite=1, immCntrl=000, aluCntrl=00000 and 01000 respectively.
REQ-046 0x022081B3 (MUL) -> with EN_M=1, aluCntrl=10000 and regWrite=1; with EN_M=0, out_ctrl=0x8000.
REQ-047 0x4030D093 (SRAI) -> aluCntrl=01101 and immCntrl=001; 0xFFF00093 (ADDI -1) -> aluCntrl=00000 and immCntrl=010.
REQ-048 Backpressure case:
- Stimulus: out_ready=0, then push A, B, C on consecutive cycles.
- in_ready SHALL drop after B is accepted, and C SHALL be held upstream.
- When out_ready rises, A, B, C SHALL emerge on consecutive cycles.
REQ-049 Flush with both entries full plus a coincident in_valid -> next cycle out_valid=0 and in_ready=1, and no entry is ever emitted.
REQ-050 rst asserted mid-stream with both entries full -> all outputs 0 and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/decode_skid_stage.sv
// RV32I(+M) decode stage with a 2-entry skid buffer (OUT + SKID).
// Instructions are decoded on entry, so both registers hold ready-to-use
// control words; in_ready is a register so upstream sees no combinational path.
module decode_skid_stage #(
  parameter int XLEN = 32,
  parameter int EN_M = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [15:0]     out_ctrl
);

  localparam logic [15:0] ILLEGAL_CTRL = 16'h8000;

  // Packed layout: {illegal, regWrite, memWrite, memRead, branch, jump,
  //                 aluSrc, inv, immCntrl[2:0], aluCntrl[4:0]}
  function automatic logic [15:0] decode_ctrl(
    input logic [1:0] lo,
    input logic [4:0] op,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    logic       ill;
    logic       rw;
    logic       mw;
    logic       mr;
    logic       br;
    logic       jmp;
    logic       inv;
    logic [2:0] imm;
    logic [4:0] alu;
    ill = 1'b0;
    rw  = 1'b0;
    mw  = 1'b0;
    mr  = 1'b0;
    br  = 1'b0;
    jmp = 1'b0;
    inv = 1'b0;
    imm = 3'b000;
    alu = 5'b00000;
    if (lo != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (op)
        5'b01100: begin
          rw = 1'b1;
          if (f7 == 7'b0000000)
            alu = {2'b00, f3};
          else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
            alu = {2'b01, f3};
          else if (f7 == 7'b0000001 && EN_M != 0)
            alu = {2'b10, f3};
          else
            ill = 1'b1;
        end
        5'b00100: begin
          rw  = 1'b1;
          imm = (f3 == 3'b001 || f3 == 3'b101) ? 3'b001 : 3'b010;
          alu = {1'b0, f7[5] & (f3 == 3'b101), f3};
          // Shift-immediates reuse f7 as a function selector, so only the
          // encodings that name a real shift are legal.
          if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
          if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
        end
        5'b00000: begin
          rw  = 1'b1;
          mr  = 1'b1;
          imm = 3'b010;
          if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
        end
        5'b01000: begin
          mw  = 1'b1;
          imm = 3'b011;
          if (f3 > 3'b010) ill = 1'b1;
        end
        5'b11000: begin
          br  = 1'b1;
          imm = 3'b100;
          alu = {3'b010, f3[2:1]};
          inv = f3[0];
          if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
        end
        5'b01101, 5'b00101: begin
          rw  = 1'b1;
          imm = 3'b101;
        end
        5'b11011: begin
          rw  = 1'b1;
          jmp = 1'b1;
          imm = 3'b110;
        end
        5'b11001: begin
          rw  = 1'b1;
          jmp = 1'b1;
          imm = 3'b010;
          if (f3 != 3'b000) ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill)
      decode_ctrl = ILLEGAL_CTRL;
    else
      decode_ctrl = {1'b0, rw, mw, mr, br, jmp, |imm, inv, imm, alu};
  endfunction

  // ---- stage p0: combinational decode of the incoming word ----
  logic [15:0] ctrl_p0;
  logic        in_hs;
  logic        out_free;
  logic        load_skid;

  // Decode and handshake qualification for the current cycle.
  always_comb begin
    ctrl_p0   = decode_ctrl(in_instr[1:0], in_instr[6:2], in_instr[14:12], in_instr[31:25]);
    in_hs     = in_valid & in_ready;
    out_free  = ~out_valid | out_ready;
    load_skid = in_hs & ~out_free;
  end

  // ---- stage p1: OUT register (ports) and SKID register ----
  logic            skid_vld_p1;
  logic [31:0]     skid_instr_p1;
  logic [XLEN-1:0] skid_pc_p1;
  logic [15:0]     skid_ctrl_p1;

  // OUT register and occupancy control; SKID drains into OUT first to keep order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_ctrl    <= '0;
      skid_vld_p1 <= 1'b0;
      in_ready    <= 1'b1;
    end else if (flush) begin
      out_valid   <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready    <= 1'b1;
    end else if (out_free) begin
      in_ready <= 1'b1;
      if (skid_vld_p1) begin
        out_valid   <= 1'b1;
        out_instr   <= skid_instr_p1;
        out_pc      <= skid_pc_p1;
        out_ctrl    <= skid_ctrl_p1;
        skid_vld_p1 <= 1'b0;
      end else if (in_hs) begin
        out_valid <= 1'b1;
        out_instr <= in_instr;
        out_pc    <= in_pc;
        out_ctrl  <= ctrl_p0;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_hs) begin
      skid_vld_p1 <= 1'b1;
      in_ready    <= 1'b0;
    end
  end

  // SKID payload; qualified by skid_vld_p1, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_instr_p1 <= in_instr;
      skid_pc_p1    <= in_pc;
      skid_ctrl_p1  <= ctrl_p0;
    end
  end

endmodule

// File: tb/tb_decode_skid_stage.sv
// Testbench for decode_skid_stage: decode vector table, directed
// backpressure/flush/reset sequences, and randomized traffic against a
// queue-based reference model.
module tb_decode_skid_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [15:0] out_ctrl;

  logic        nm_in_ready;
  logic        nm_out_valid;
  logic [31:0] nm_out_instr;
  logic [31:0] nm_out_pc;
  logic [15:0] nm_out_ctrl;

  decode_skid_stage #(.XLEN(32), .EN_M(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_ctrl(out_ctrl)
  );

  decode_skid_stage #(.XLEN(32), .EN_M(0)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nm_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(nm_out_valid), .out_ready(out_ready), .out_instr(nm_out_instr),
    .out_pc(nm_out_pc), .out_ctrl(nm_out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  bit   mvalid = 0;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] c_m;
    logic [15:0] c_nm;
  } vec_t;

  vec_t vecs[24];

  logic [4:0] ops[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode written straight from the instruction-set rules.
  function automatic logic [15:0] ref_ctrl(input logic [31:0] i, input bit en_m);
    int  op, f3, f7;
    int  rw, mw, mr, br, jmp, inv, imm, alu;
    bit  legal;
    op = int'(i[6:2]); f3 = int'(i[14:12]); f7 = int'(i[31:25]);
    rw = 0; mw = 0; mr = 0; br = 0; jmp = 0; inv = 0; imm = 0; alu = 0;
    legal = 1;
    if (i[1:0] != 2'b11) return 16'h8000;
    case (op)
      12: begin
        rw = 1;
        if (f7 == 0) alu = f3;
        else if (f7 == 32 && (f3 == 0 || f3 == 5)) alu = 8 + f3;
        else if (f7 == 1 && en_m) alu = 16 + f3;
        else legal = 0;
      end
      4: begin
        rw = 1;
        imm = (f3 == 1 || f3 == 5) ? 1 : 2;
        alu = f3 + ((f3 == 5 && i[30]) ? 8 : 0);
        if (f3 == 1 && f7 != 0) legal = 0;
        if (f3 == 5 && f7 != 0 && f7 != 32) legal = 0;
      end
      0: begin
        rw = 1; mr = 1; imm = 2;
        if (f3 == 3 || f3 == 6 || f3 == 7) legal = 0;
      end
      8: begin
        mw = 1; imm = 3;
        if (f3 > 2) legal = 0;
      end
      24: begin
        br = 1; imm = 4; alu = 8 + f3 / 2; inv = f3 % 2;
        if (f3 == 2 || f3 == 3) legal = 0;
      end
      13, 5: begin rw = 1; imm = 5; end
      27: begin rw = 1; jmp = 1; imm = 6; end
      25: begin
        rw = 1; jmp = 1; imm = 2;
        if (f3 != 0) legal = 0;
      end
      default: legal = 0;
    endcase
    if (!legal) return 16'h8000;
    return 16'(rw * 16384 + mw * 8192 + mr * 4096 + br * 2048 + jmp * 1024 +
               ((imm != 0) ? 512 : 0) + inv * 256 + imm * 32 + alu);
  endfunction

  task automatic model_check();
    if (!mvalid) return;
    chk("in_ready", in_ready, (q.size() < 2));
    chk("out_valid", out_valid, (q.size() > 0));
    chk("nm_out_valid", nm_out_valid, (q.size() > 0));
    if (q.size() > 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_ctrl", out_ctrl, ref_ctrl(q[0].instr, 1'b1));
      chk("nm_out_ctrl", nm_out_ctrl, ref_ctrl(q[0].instr, 1'b0));
    end
  endtask

  task automatic model_update();
    bit acc;
    ent_t e;
    if (rst) begin
      q.delete();
      mvalid = 1;
    end else if (!mvalid) begin
      return;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      e.instr = in_instr;
      e.pc    = in_pc;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  // One clock: check and advance the model mid-cycle, then return just after the edge.
  task automatic cycle();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 8) begin
      w[6:0] = {ops[$urandom_range(0, 9)], 2'b11};
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    cycle();
  endtask

  initial begin
    ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
            5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00100};
    vecs = '{
      '{32'h002081B3, 16'h4000, 16'h4000},  // ADD
      '{32'h402081B3, 16'h4008, 16'h4008},  // SUB
      '{32'h022081B3, 16'h4010, 16'h8000},  // MUL
      '{32'h4030D093, 16'h422D, 16'h422D},  // SRAI
      '{32'hFFF00093, 16'h4240, 16'h4240},  // ADDI -1
      '{32'h00101093, 16'h4221, 16'h4221},  // SLLI
      '{32'h02001093, 16'h8000, 16'h8000},  // SLLI bad f7
      '{32'h00002083, 16'h5240, 16'h5240},  // LW
      '{32'h00003083, 16'h8000, 16'h8000},  // load f3=011
      '{32'h00002023, 16'h2260, 16'h2260},  // SW
      '{32'h00003023, 16'h8000, 16'h8000},  // store f3=011
      '{32'h00000063, 16'h0A88, 16'h0A88},  // BEQ
      '{32'h00001063, 16'h0B88, 16'h0B88},  // BNE
      '{32'h00007063, 16'h0B8B, 16'h0B8B},  // BGEU
      '{32'h00002063, 16'h8000, 16'h8000},  // branch f3=010
      '{32'h000000B7, 16'h42A0, 16'h42A0},  // LUI
      '{32'h00000097, 16'h42A0, 16'h42A0},  // AUIPC
      '{32'h0000006F, 16'h46C0, 16'h46C0},  // JAL
      '{32'h00000067, 16'h4640, 16'h4640},  // JALR
      '{32'h00001067, 16'h8000, 16'h8000},  // JALR f3=001
      '{32'h40001033, 16'h8000, 16'h8000},  // R-type f7=0100000 f3=001
      '{32'h00000001, 16'h8000, 16'h8000},  // compressed
      '{32'h0000007F, 16'h8000, 16'h8000},  // unknown op
      '{32'h022091B3, 16'h4011, 16'h8000}   // MULH
    };

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h002081B3; in_pc = 32'h0;
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_ctrl", out_ctrl, 16'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    rst = 1'b0;

    // Back-to-back decode table with the sink always ready.
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      push(vecs[k].instr, 32'h1000 + 32'(4 * k));
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_instr", out_instr, vecs[k].instr);
      chk("vec_ctrl_m", out_ctrl, vecs[k].c_m);
      chk("vec_ctrl_nm", nm_out_ctrl, vecs[k].c_nm);
    end
    in_valid = 1'b0;
    cycle();
    chk("drain_valid", out_valid, 1'b0);

    // Backpressure: A, B accepted, C held upstream, then A B C in order.
    out_ready = 1'b0;
    push(32'hA00000B7, 32'hA);
    chk("bp_a_ready", in_ready, 1'b1);
    push(32'hB00000B7, 32'hB);
    chk("bp_b_ready", in_ready, 1'b0);
    push(32'hC00000B7, 32'hC);
    chk("bp_c_held", in_ready, 1'b0);
    chk("bp_out_a", out_instr, 32'hA00000B7);
    out_ready = 1'b1;
    cycle();
    chk("bp_out_b", out_instr, 32'hB00000B7);
    chk("bp_b_valid", out_valid, 1'b1);
    cycle();
    chk("bp_out_c", out_instr, 32'hC00000B7);
    chk("bp_c_pc", out_pc, 32'hC);
    in_valid = 1'b0;
    cycle();
    chk("bp_empty", out_valid, 1'b0);

    // Flush with both entries full and a coincident in_valid.
    out_ready = 1'b0;
    push(32'h00000013, 32'h20);
    push(32'h00100093, 32'h24);
    chk("fl_full", in_ready, 1'b0);
    flush = 1'b1;
    push(32'h00200113, 32'h28);
    flush = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("fl_no_emit", out_valid, 1'b0);
    end
    // Flush while empty discards an accepted handshake.
    flush = 1'b1;
    push(32'h00300193, 32'h2C);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_discard", out_valid, 1'b0);
    cycle();
    chk("fl_discard2", out_valid, 1'b0);

    // Reset mid-stream with both entries full.
    out_ready = 1'b0;
    push(32'h002081B3, 32'h40);
    push(32'h402081B3, 32'h44);
    rst = 1'b1;
    push(32'h022081B3, 32'h48);
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_ctrl", out_ctrl, 16'h0);
    chk("mrst_instr", out_instr, 32'h0);
    chk("mrst_pc", out_pc, 32'h0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      in_instr  = gen_instr();
      in_pc     = $urandom;
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
